// File: rtl/datapath_acc_mc.sv
// ---------------------------------------------------------------------------
// datapath_acc_mc
//
// Accumulator datapath with a small ALU and a multi-cycle shift-add
// multiplier. Commands are accepted on a rising edge where Start=1 and the
// unit is idle. Single-cycle commands write Acc on the accepting edge, and
// Done pulses in the following cycle. MUL commands run for exactly N edges
// with Busy high. The product is written on the last of those edges.
//
// Parameters
//   N       datapath width (>= 4)
//   ADDR_W  immediate width (<= N)
//   SEXT    1 = sign-extend the immediate, 0 = zero-extend it
//
// Ports
//   clk       clock, rising edge
//   Reset     synchronous active-high reset
//   Start     command strobe, sampled when Busy=0
//   SelA      Acc source: 00 ALU, 01 ImmExt, 10 Out_Data, 11 no load
//   SelB      ALU operand B: 0 ImmExt, 1 Out_Data
//   WrAcc     Acc write enable for the command
//   Op        ADD, SUB, AND, OR, XOR, SHL1, SRA1, MUL
//   Clear     synchronous clear of Acc and flags (ignored while Busy)
//   Out_Data  data read from memory
//   Addr      immediate operand
//   In_Data   data to memory (mirrors Acc)
//   Acc       accumulator
//   Busy      high while a MUL is running
//   Done      one-cycle completion pulse
//   Zero      set when the last Acc write was zero
//   Carry     carry (ADD) / borrow (SUB) of the last ALU arithmetic write
// ---------------------------------------------------------------------------
module datapath_acc_mc #(
  parameter int N      = 16,
  parameter int ADDR_W = 11,
  parameter int SEXT   = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        SelA,
  input  logic              SelB,
  input  logic              WrAcc,
  input  logic [2:0]        Op,
  input  logic              Clear,
  input  logic [N-1:0]      Out_Data,
  input  logic [ADDR_W-1:0] Addr,
  output logic [N-1:0]      In_Data,
  output logic [N-1:0]      Acc,
  output logic              Busy,
  output logic              Done,
  output logic              Zero,
  output logic              Carry
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL1 = 3'b101;
  localparam logic [2:0] OP_SRA1 = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam int          CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    acc_q, acc_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic            done_q, done_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [N-1:0]    prod_q, prod_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [N-1:0]    imm_ext;
  logic [N-1:0]    b_op;
  logic [N:0]      add_full;
  logic [N:0]      sub_full;
  logic [N-1:0]    alu_res;
  logic            alu_carry;
  logic [N-1:0]    prod_sum;
  logic            accept;
  logic            is_mul_cmd;
  logic [N-1:0]    src_val;

  // Immediate extension: upper bits are filled only when sign extension is
  // enabled and the immediate MSB is set. The loop also covers ADDR_W == N.
  always_comb begin
    imm_ext = '0;
    imm_ext[ADDR_W-1:0] = Addr;
    if (SEXT != 0 && Addr[ADDR_W-1]) begin
      for (int i = ADDR_W; i < N; i++) begin
        imm_ext[i] = 1'b1;
      end
    end
  end

  assign b_op = SelB ? Out_Data : imm_ext;

  // The borrow is the top bit of the widened difference (set when A < B).
  assign add_full = {1'b0, acc_q} + {1'b0, b_op};
  assign sub_full = {1'b0, acc_q} - {1'b0, b_op};

  // Single-cycle ALU. MUL is handled by the sequencer, so its slot here is
  // unused and returns zero.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (Op)
      OP_ADD:  begin alu_res = add_full[N-1:0]; alu_carry = add_full[N]; end
      OP_SUB:  begin alu_res = sub_full[N-1:0]; alu_carry = sub_full[N]; end
      OP_AND:  alu_res = acc_q & b_op;
      OP_OR:   alu_res = acc_q | b_op;
      OP_XOR:  alu_res = acc_q ^ b_op;
      OP_SHL1: alu_res = {acc_q[N-2:0], 1'b0};
      OP_SRA1: alu_res = {acc_q[N-1], acc_q[N-1:1]};
      default: alu_res = '0;
    endcase
  end

  // Accumulator source mux. Code 11 means no load; the write is suppressed
  // elsewhere, so this arm is unused.
  always_comb begin
    src_val = '0;
    case (SelA)
      2'b00:   src_val = alu_res;
      2'b01:   src_val = imm_ext;
      2'b10:   src_val = Out_Data;
      default: src_val = acc_q;
    endcase
  end

  // Clear wins over Start on the same idle edge.
  assign accept     = Start && (state_q == IDLE) && !Clear;
  assign is_mul_cmd = (Op == OP_MUL) && (SelA == 2'b00) && WrAcc;

  assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

  // FSM state register. It also holds every datapath flop.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic. MUL lasts N edges: counts 0..N-1, and the exit
  // happens on the edge that sees the last count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mul_cmd) state_d = MUL;
      MUL:  if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  // In IDLE, Clear resets Acc and flags to their reset values, and an
  // accepted command either writes Acc directly or latches the MUL operands.
  // In MUL, each edge adds the shifted multiplicand when the current
  // multiplier LSB is set. The final edge writes the product.
  always_comb begin
    acc_d    = acc_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (Clear) begin
          acc_d   = '0;
          zero_d  = 1'b1;
          carry_d = 1'b0;
        end else if (accept) begin
          if (is_mul_cmd) begin
            mcand_d  = acc_q;
            mplier_d = b_op;
            prod_d   = '0;
            cnt_d    = '0;
          end else begin
            done_d = 1'b1;
            if (WrAcc && SelA != 2'b11) begin
              acc_d  = src_val;
              zero_d = (src_val == '0);
              if (SelA == 2'b00 && (Op == OP_ADD || Op == OP_SUB)) begin
                carry_d = alu_carry;
              end
            end
          end
        end
      end
      MUL: begin
        prod_d   = prod_sum;
        mcand_d  = {mcand_q[N-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[N-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          acc_d  = prod_sum;
          zero_d = (prod_sum == '0);
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // FSM outputs.
  always_comb begin
    Busy = (state_q == MUL);
  end

  assign Acc     = acc_q;
  assign In_Data = acc_q;
  assign Done    = done_q;
  assign Zero    = zero_q;
  assign Carry   = carry_q;

endmodule
